// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-RAM subsystem: FSM states, command codes, frame width.
package spi_pkg;

  localparam int FRAME_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_slave_fe_if.sv
// SPI pins plus the parallel RAM-side handshake of the SPI front end.
interface spi_slave_fe_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  // Front end side: consumes SPI pins and RAM read data, produces frames and MISO.
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  // SPI master / RAM side.
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// MISO serializer: loads a RAM read byte and shifts it out MSB first, one bit per clk.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;    // bits still to present after the current one
  logic              busy;

  // MSB goes out on the load edge itself; after the last bit MISO drops back to 0.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      miso  <= 1'b0;
    end else if (load) begin
      miso  <= din[DATA_W-1];
      shreg <= {din[DATA_W-2:0], 1'b0};
      cnt   <= CNT_W'(DATA_W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        miso  <= shreg[DATA_W-1];
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end else begin
        miso  <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_fe.sv
// SPI slave front end: deserialises MOSI frames into rx_data/rx_valid and returns
// RAM read data on MISO after a read-data frame.
module spi_slave_fe
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  spi_slave_fe_if.slave bus
);

  localparam int FW    = DATA_W + 2;
  localparam int CNT_W = $clog2(FW + 1);
  localparam int WC_W  = $clog2(TX_WAIT_MAX + 1);

  spi_state_e       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [FW-2:0]    rx_shift;
  logic [FW-1:0]    rx_frame;
  logic             rd_addr_done;
  logic             waiting;
  logic [WC_W-1:0]  wait_cnt;
  logic             rcv_state, shift_en, frame_done, tx_load;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: bit9 picks write vs read, rd_addr_done picks address vs data read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)          state_nxt = IDLE;
        else if (!bus.MOSI)    state_nxt = WRITE;
        else if (!rd_addr_done) state_nxt = READ_ADD;
        else                   state_nxt = READ_DATA;
      end
      default: if (bus.SS_n) state_nxt = IDLE;
    endcase
  end

  // Frame assembly strobes; the counter saturates at FW so trailing bits are ignored.
  always_comb begin
    rx_frame   = {rx_shift, bus.MOSI};
    rcv_state  = state inside {WRITE, READ_ADD, READ_DATA};
    shift_en   = !bus.SS_n && (state == CHK_CMD || (rcv_state && bit_cnt < CNT_W'(FW)));
    frame_done = shift_en && rcv_state && bit_cnt == CNT_W'(FW - 1);
    tx_load    = waiting && !bus.SS_n && bus.tx_valid;
  end

  // Receive shift, frame completion, read-address tracking and the tx_valid wait window.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rd_addr_done <= 1'b0;
      waiting      <= 1'b0;
      wait_cnt     <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (bus.SS_n || state == IDLE) begin
        bit_cnt  <= '0;
        waiting  <= 1'b0;
        wait_cnt <= '0;
      end else begin
        if (shift_en) begin
          rx_shift <= rx_frame[FW-2:0];
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (frame_done) begin
          bus.rx_data  <= rx_frame;
          bus.rx_valid <= 1'b1;
          // Tracked from the received command bits, not the route taken.
          if (rx_frame[FW-1 -: 2] == CMD_RD_ADDR)      rd_addr_done <= 1'b1;
          else if (rx_frame[FW-1 -: 2] == CMD_RD_DATA) rd_addr_done <= 1'b0;
          if (state == READ_DATA && rx_frame[FW-1 -: 2] == CMD_RD_DATA) begin
            waiting  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        if (waiting) begin
          if (bus.tx_valid || wait_cnt == WC_W'(TX_WAIT_MAX - 1)) waiting <= 1'b0;
          else                                                    wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .abort (bus.SS_n),
    .load  (tx_load),
    .din   (bus.tx_data),
    .miso  (bus.MISO)
  );

endmodule

// File: doc/spi_slave_fe.md
Name: spi_slave_fe

Overview:
- Serial front end of the SPI-RAM subsystem, directly upstream of the single-port RAM stage.
- Deserialises 10-bit MOSI frames into a parallel command word `rx_data` with a one-cycle `rx_valid` strobe.
- On a read-data frame, waits for the RAM's `tx_valid`/`tx_data` response and serialises the 8-bit result on MISO.
- SPI bit rate equals `clk`: one MOSI/MISO bit per `clk` while `SS_n` is low.

Parameters:
- `DATA_W`, 8: RAM data/address width; frame width is `DATA_W+2`.
- `TX_WAIT_MAX`, 4: maximum cycles to wait for `tx_valid` after a read-data frame before abandoning the read.

Ports:
- `clk`  in  1  system clock, also the SPI bit clock
- `rst`  in  1  synchronous active-high reset
- `SS_n`  in  1  slave select, active low; frames one transaction
- `MOSI`  in  1  serial data in, MSB first
- `MISO`  out  1  serial data out, MSB first
- `rx_data`  out  10  received frame; [9:8] command, [7:0] address/data
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid
- `tx_data`  in  8  read data from RAM
- `tx_valid`  in  1  `tx_data` valid strobe from RAM

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - Outputs: `MISO`=0, `rx_data`=0, `rx_valid`=0.
  - Internal: state=IDLE, bit counter=0, shift registers=0, `rd_addr_done`=0, wait counter=0.
- Command codes, carried in `rx_data[9:8]`:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read data
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: on `SS_n` sampled low at edge N, go to CHK_CMD. `MISO`=0.
- CHK_CMD (edge N+1):
  - Sample MOSI as bit9 into the shift register.
  - If bit9=0, go to WRITE.
  - If bit9=1 and `rd_addr_done`=0, go to READ_ADD.
  - If bit9=1 and `rd_addr_done`=1, go to READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Bits 8..0 are sampled at edges N+2..N+10.
  - At edge N+10, `rx_data` is loaded with the full frame and `rx_valid` goes to 1 for exactly one cycle.
  - `rx_data` holds its value until the next completed frame.
- `rd_addr_done` is updated at frame completion from the received bits[9:8], not from the state: set on 10, cleared on 11, unchanged on 00/01.
- Bits after the 10th while `SS_n` stays low are ignored; the counter saturates and no second `rx_valid` is produced.
- READ_DATA, after frame completion (received bits 11):
  - Wait for `tx_valid`=1, nominally at edge N+11 from the RAM.
  - On sampling `tx_valid`, load `tx_data` into the TX shift register.
  - `MISO` = bit7 after that edge, then one bit per edge through bit0.
  - After bit0, `MISO` returns to 0.
  - If `tx_valid` is not seen within `TX_WAIT_MAX` cycles after `rx_valid`, abandon the read: `MISO` stays 0 and `rd_addr_done` is already cleared.
  - `tx_valid` in any other state, or outside the wait window, is ignored.
- `SS_n` high in any non-IDLE state:
  - Go to IDLE on that edge and clear the counters.
  - Abort any in-progress MOSI shift (no `rx_valid`) or MISO shift (`MISO`=0).
  - `rd_addr_done` is unchanged by an aborted frame.
  - A frame whose 10th bit is sampled on the same edge that `SS_n` is seen low still completes.
- `rst` mid-frame has priority over everything: all state is returned to reset values on that edge.
- Back-to-back frames: `SS_n` high for one cycle, then low again, starts a new frame; no minimum gap beyond one IDLE cycle.

Decomposition:
- `spi_pkg` holds:
  - state enum `spi_state_e`
  - command constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`
  - `FRAME_W`=10
  - shared with the RAM and the bench
- One natural sub-module: `spi_tx_serializer`.
  - Holds the load/shift register, 3-bit count and busy flag for MISO.
  - Has its own abort input driven by `SS_n`.

Test Plan:
- Write sequence:
  - Stimulus: frames 00_0x3C then 01_0xA5, `SS_n` high one cycle between them.
  - Required: `rx_valid` pulses with `rx_data`=0x03C then 0x1A5, each at edge N+10 of its frame.
  - Required: `MISO` stays 0 throughout.
- Read sequence:
  - Stimulus: frame 10_0x3C, then frame 11_0x00; model the RAM returning `tx_valid`/`tx_data`=0xA5 one cycle after `rx_valid`.
  - Required: `rx_data`=0x23C then 0x300.
  - Required: `MISO` serialises 1,0,1,0,0,1,0,1 on consecutive cycles.
- Abort:
  - Stimulus: `SS_n` raised after 6 bits of frame 01_0xFF.
  - Required: no `rx_valid`; state IDLE next cycle; the next full frame 00_0x01 is received correctly.
- Read timeout:
  - Stimulus: frame 10_0x10, then frame 11_xx with `tx_valid` never asserted.
  - Required: `MISO`=0 throughout.
  - Required: a following bit9=1 frame is routed to READ_ADD (`rd_addr_done`=0).
- Reset mid-read:
  - Stimulus: assert `rst` during the 4th `MISO` bit.
  - Required: `MISO`=0 and `rx_valid`=0 on the next cycle; `rd_addr_done`=0.
- Extra bits:
  - Stimulus: 14 bits clocked under one `SS_n` low period, first 10 = 00_0x55.
  - Required: exactly one `rx_valid`, with `rx_data`=0x055.
